// File: rtl/conv3x3_engine.sv
// conv3x3_engine: sweeps all 36 3x3 windows of an 8x8 image and emits a signed 9-tap dot product per window.
// Build option: define CONV3X3_RELU_EN to clamp negative results to zero.
module conv3x3_engine #(
    parameter int ACC_W   = 21,
    parameter int POS_MAX = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [71:0]      kernel,
    output logic             busy,
    output logic [5:0]       win_addr,
    output logic             win_rd_en,
    input  logic [71:0]      win_data,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic             done
);

    localparam logic [2:0] PMAX = 3'(POS_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_MUL,
        S_ADD,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        x_q, y_q;
    logic [71:0]       kern_q;
    logic [71:0]       win_q;
    logic signed [16:0] prod_q [9];
    logic signed [16:0] prod_c [9];
    logic [ACC_W-1:0]  sum_c;
    logic [ACC_W-1:0]  res_nxt;
    logic              last_c;

    assign win_addr = {x_q, y_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        win_rd_en = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_RD;
            end
            S_RD: begin
                win_rd_en = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: state_nxt = S_MUL;
            S_MUL: state_nxt = S_ADD;
            S_ADD: state_nxt = S_OUT;
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = res_last ? S_DONE : S_RD;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pixels are unsigned: zero-extend them, sign-extend weights, 17-bit product
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_c[i] = $signed({9'b0, win_q[8*i +: 8]})
                      * $signed({{9{kern_q[8*i+7]}}, kern_q[8*i +: 8]});
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + {{(ACC_W-17){prod_q[i][16]}}, prod_q[i]};
        end
    end

`ifdef CONV3X3_RELU_EN
    assign res_nxt = sum_c[ACC_W-1] ? '0 : sum_c;
`else
    assign res_nxt = sum_c;
`endif

    assign last_c = (x_q == PMAX) && (y_q == PMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            kern_q   <= '0;
            win_q    <= '0;
            res_data <= '0;
            res_last <= 1'b0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                kern_q <= kernel;
                x_q    <= '0;
                y_q    <= '0;
            end
            if (state == S_CAP) win_q <= win_data;
            if (state == S_MUL) begin
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
            end
            if (state == S_ADD) begin
                res_data <= res_nxt;
                res_last <= last_c;
            end
            // x is the fast index; wrap moves down one row
            if (state == S_OUT && res_ready) begin
                res_last <= 1'b0;
                if (!res_last) begin
                    if (x_q == PMAX) begin
                        x_q <= '0;
                        y_q <= y_q + 3'd1;
                    end else begin
                        x_q <= x_q + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Downstream consumer of the 8x8 pixel window buffer.
- Sweeps every valid 3x3 window top-left position over the 8x8 image and issues the window address and read enable to the buffer.
- Captures the 72-bit window one cycle later and computes a signed 9-tap dot product against a kernel latched at start.
- Emits one result per window over a valid/ready handshake.

Parameters:
- ACC_W, 21: result width, signed. Default holds the exact worst case, 9 x 255 x (-128) = -293760.
- POS_MAX, 5: last top-left coordinate on each axis (8 - 3). Gives 36 windows.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; starts a sweep, accepted only in IDLE
- kernel  input  72  nine signed 8-bit weights, byte order matches win_data; latched on an accepted start
- busy  output  1  high from accepted start until the DONE state exits
- win_addr  output  6  window top-left address: [5:3] = x (column, fast index), [2:0] = y (row)
- win_rd_en  output  1  read strobe to the window buffer
- win_data  input  72  buffer window, valid the cycle after win_rd_en. [71:48] = row y {p(x,y), p(x+1,y), p(x+2,y)}, [47:24] = row y+1, [23:0] = row y+2
- res_data  output  ACC_W  signed dot product for the current window
- res_valid  output  1  result valid; held until accepted
- res_ready  input  1  downstream accept
- res_last  output  1  high with res_valid on the 36th window
- done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. All outputs 0: busy, win_addr, win_rd_en, res_data, res_valid, res_last, done. Position counters and kernel register cleared.
- Pixels are unsigned 8-bit; weights are signed 8-bit.
- Product k_i x p_i: zero-extend the pixel to 9 bits, signed multiply, 17-bit signed result.
- Sum of the 9 products is sign-extended to ACC_W. No truncation at the default width.
- Byte i of kernel multiplies byte i of win_data (byte 8 = bits [71:64] ... byte 0 = bits [7:0]).
- FSM states:
  - IDLE: wait for start. On start, latch kernel, set x=y=0, busy=1, go to RD.
  - RD: win_addr={x,y}, win_rd_en=1 for exactly this one cycle, go to CAP.
  - CAP: register win_data, go to MUL.
  - MUL: register the 9 products, go to ADD.
  - ADD: register the adder-tree sum into res_data. Set res_last if x==POS_MAX and y==POS_MAX. Go to OUT.
  - OUT: res_valid=1, with res_data and res_last stable. On res_valid && res_ready:
    - drop res_valid;
    - if last window, go to DONE;
    - else advance x (on wrap at POS_MAX: x=0, y+1) and go to RD.
  - DONE: done=1 for one cycle, busy=0 on exit, go to IDLE.
- Latency: res_valid rises 4 cycles after the win_rd_en cycle.
- Throughput: minimum 5 cycles per window with res_ready held high. Full sweep completes in 180 cycles plus the DONE cycle.
- Backpressure: no new win_rd_en is issued while OUT waits on res_ready.
- start while busy (including the DONE cycle) is ignored. kernel changes after latch are ignored.
- win_rd_en is never asserted outside RD. win_addr holds its last value between reads.

Optional Feature:
- Macro: CONV3X3_RELU_EN.
- Defined: the ADD state registers max(sum, 0). Negative results become 0; the res_data sign bit is always 0.
- Undefined: the raw signed sum is output.
- Handshake and timing are identical in both builds.

Test Plan:
- All pixels 1, kernel all +1, res_ready=1 -> 36 results, each 9. res_last only on the 36th. done pulses once, 1 cycle after that handshake. Reads occur 5 cycles apart.
- Pixel value = x + 8y, kernel centre weight (bits [39:32]) = 1, others 0 -> results equal p(x+1,y+1). First result 9, 7th result 17, last result 54. win_addr sequence: 0x00, 0x08, ..., 0x28, 0x01, ...
- Backpressure: res_ready low for 5 cycles while the 3rd result is presented -> res_data and res_valid held, no win_rd_en during the stall, all 36 results delivered in order.
- Pixels all 255, kernel all -128 -> every result = -293760 (21-bit two's complement). With CONV3X3_RELU_EN -> every result 0.
- rst_n low for 1 cycle after the 10th result -> all outputs 0 immediately, FSM in IDLE. A subsequent start restarts at win_addr 0x00.
- start pulsed again mid-sweep with a different kernel -> ignored. Results still use the original kernel; exactly 36 results and one done pulse.
